// File: rtl/tod_alarm_clock.sv
// Time-of-day core: prescaled seconds tick, ss/mm/hh cascade, time-set and hh:mm alarm slots.
// Optional BCD display outputs are compiled in when TOD_BCD_OUT_EN is defined.
module tod_alarm_clock #(
    parameter int CLK_HZ     = 50000000,
    parameter int DAY_HOURS  = 24,
    parameter int NUM_ALARMS = 4,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  set_en,
    input  logic [4:0]            set_hh,
    input  logic [5:0]            set_mm,
    input  logic [5:0]            set_ss,
    output logic                  set_err,
    input  logic                  alm_we,
    input  logic [AW-1:0]         alm_idx,
    input  logic [4:0]            alm_hh,
    input  logic [5:0]            alm_mm,
    input  logic                  alm_on,
    output logic [4:0]            hh,
    output logic [5:0]            mm,
    output logic [5:0]            ss,
    output logic                  sec_pulse,
    output logic                  min_pulse,
    output logic                  hour_pulse,
    output logic                  day_pulse,
`ifdef TOD_BCD_OUT_EN
    output logic [7:0]            bcd_hh,
    output logic [7:0]            bcd_mm,
    output logic [7:0]            bcd_ss,
`endif
    output logic [NUM_ALARMS-1:0] alarm_hit
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [5:0]    HH_LIM  = 6'(DAY_HOURS);
    localparam logic [4:0]    HH_MAX  = 5'(DAY_HOURS - 1);
    localparam logic [AW:0]   IDX_LIM = (AW + 1)'(NUM_ALARMS);

    logic [PW-1:0]         presc_reg;
    logic [4:0]            hh_reg;
    logic [5:0]            mm_reg, ss_reg;
    logic                  sec_pulse_reg, min_pulse_reg, hour_pulse_reg, day_pulse_reg;
    logic                  set_err_reg;
    logic [NUM_ALARMS-1:0] hit_pend_reg, alarm_hit_reg;

    logic                  tick, set_ok, alm_ok;
    logic                  ss_wrap, mm_wrap, hh_wrap;
    logic [4:0]            hh_next;
    logic [5:0]            mm_next, ss_next;
    logic [NUM_ALARMS-1:0] slot_match, hit_pend_next;

    assign tick   = run && (presc_reg == PRE_MAX);
    assign set_ok = ({1'b0, set_hh} < HH_LIM) && (set_mm < 6'd60) && (set_ss < 6'd60);
    assign alm_ok = ({1'b0, alm_idx} < IDX_LIM) && ({1'b0, alm_hh} < HH_LIM) && (alm_mm < 6'd60);

    // Whole-cascade next value, so every rollover pulse lands in the same cycle.
    always_comb begin
        ss_wrap = (ss_reg == 6'd59);
        mm_wrap = ss_wrap && (mm_reg == 6'd59);
        hh_wrap = mm_wrap && (hh_reg == HH_MAX);
        ss_next = ss_wrap ? 6'd0 : ss_reg + 6'd1;
        mm_next = ss_wrap ? (mm_wrap ? 6'd0 : mm_reg + 6'd1) : mm_reg;
        hh_next = mm_wrap ? (hh_wrap ? 5'd0 : hh_reg + 5'd1) : hh_reg;
        // Evaluated against the pre-edge slot contents, so a same-cycle write is not seen.
        hit_pend_next = (tick && !set_en && ss_wrap) ? slot_match : '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_reg      <= '0;
            hh_reg         <= '0;
            mm_reg         <= '0;
            ss_reg         <= '0;
            sec_pulse_reg  <= 1'b0;
            min_pulse_reg  <= 1'b0;
            hour_pulse_reg <= 1'b0;
            day_pulse_reg  <= 1'b0;
            set_err_reg    <= 1'b0;
            hit_pend_reg   <= '0;
            alarm_hit_reg  <= '0;
        end else begin
            sec_pulse_reg  <= 1'b0;
            min_pulse_reg  <= 1'b0;
            hour_pulse_reg <= 1'b0;
            day_pulse_reg  <= 1'b0;
            set_err_reg    <= 1'b0;
            hit_pend_reg   <= hit_pend_next;
            alarm_hit_reg  <= hit_pend_reg;
            if (set_en) begin
                // A set swallows any coincident tick, valid or not.
                if (set_ok) begin
                    hh_reg    <= set_hh;
                    mm_reg    <= set_mm;
                    ss_reg    <= set_ss;
                    presc_reg <= '0;
                end else begin
                    set_err_reg <= 1'b1;
                    if (run)
                        presc_reg <= tick ? '0 : presc_reg + 1'b1;
                end
            end else if (run) begin
                presc_reg <= tick ? '0 : presc_reg + 1'b1;
                if (tick) begin
                    ss_reg         <= ss_next;
                    mm_reg         <= mm_next;
                    hh_reg         <= hh_next;
                    sec_pulse_reg  <= 1'b1;
                    min_pulse_reg  <= ss_wrap;
                    hour_pulse_reg <= mm_wrap;
                    day_pulse_reg  <= hh_wrap;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
            logic [4:0] slot_hh_reg;
            logic [5:0] slot_mm_reg;
            logic       slot_on_reg;

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    slot_hh_reg <= '0;
                    slot_mm_reg <= '0;
                    slot_on_reg <= 1'b0;
                end else if (alm_we && alm_ok && (alm_idx == AW'(gi))) begin
                    slot_hh_reg <= alm_hh;
                    slot_mm_reg <= alm_mm;
                    slot_on_reg <= alm_on;
                end
            end

            assign slot_match[gi] = slot_on_reg && (slot_hh_reg == hh_next) && (slot_mm_reg == mm_next);
        end
    endgenerate

    assign hh         = hh_reg;
    assign mm         = mm_reg;
    assign ss         = ss_reg;
    assign sec_pulse  = sec_pulse_reg;
    assign min_pulse  = min_pulse_reg;
    assign hour_pulse = hour_pulse_reg;
    assign day_pulse  = day_pulse_reg;
    assign set_err    = set_err_reg;
    assign alarm_hit  = alarm_hit_reg;

`ifdef TOD_BCD_OUT_EN
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign bcd_hh = to_bcd({1'b0, hh_reg});
    assign bcd_mm = to_bcd(mm_reg);
    assign bcd_ss = to_bcd(ss_reg);
`endif

endmodule

// File: tb/tb_tod_alarm_clock.sv
// Scoreboard bench for tod_alarm_clock (CLK_HZ=4): stimulus queues expected snapshots,
// a negedge monitor pops one whenever the DUT pulses or the stimulus requests a probe.
module tb_tod_alarm_clock;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       run      = 1'b0;
    logic       set_en   = 1'b0;
    logic [4:0] set_hh   = '0;
    logic [5:0] set_mm   = '0;
    logic [5:0] set_ss   = '0;
    logic       alm_we   = 1'b0;
    logic [1:0] alm_idx  = '0;
    logic [4:0] alm_hh   = '0;
    logic [5:0] alm_mm   = '0;
    logic       alm_on   = 1'b0;
    logic       set_err;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic       sec_pulse, min_pulse, hour_pulse, day_pulse;
    logic [3:0] alarm_hit;
`ifdef TOD_BCD_OUT_EN
    logic [7:0] bcd_hh, bcd_mm, bcd_ss;
`endif

    tod_alarm_clock #(.CLK_HZ(4), .DAY_HOURS(24), .NUM_ALARMS(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .run(run),
        .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_err(set_err),
        .alm_we(alm_we), .alm_idx(alm_idx), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_on(alm_on),
        .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse), .day_pulse(day_pulse),
`ifdef TOD_BCD_OUT_EN
        .bcd_hh(bcd_hh), .bcd_mm(bcd_mm), .bcd_ss(bcd_ss),
`endif
        .alarm_hit(alarm_hit)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // pulses = {day, hour, min, sec}
    typedef struct {
        string      tag;
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [3:0] pulses;
        logic       serr;
        logic [3:0] hit;
        logic [23:0] bcd;
        bit         use_bcd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic probe = 1'b0;
    logic fin   = 1'b0;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic expect_ev(input string tag, input int h, input int m, input int s,
                             input logic [3:0] p, input logic e, input logic [3:0] hit,
                             input logic [23:0] bcd = '0, input bit use_bcd = 1'b0);
        exp_t x;
        x.tag = tag; x.hh = 5'(h); x.mm = 6'(m); x.ss = 6'(s);
        x.pulses = p; x.serr = e; x.hit = hit; x.bcd = bcd; x.use_bcd = use_bcd;
        q.push_back(x);
    endtask

    task automatic check_now(input string tag, input int h, input int m, input int s,
                             input logic [3:0] p, input logic e, input logic [3:0] hit,
                             input logic [23:0] bcd = '0, input bit use_bcd = 1'b0);
        expect_ev(tag, h, m, s, p, e, hit, bcd, use_bcd);
        probe = 1'b1;
        @(negedge CLOCK_50);
        #1;
        probe = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        set_en = 1'b1; set_hh = 5'(h); set_mm = 6'(m); set_ss = 6'(s);
        step();
        set_en = 1'b0;
    endtask

    task automatic alm_write(input int idx, input int h, input int m, input logic on);
        alm_we = 1'b1; alm_idx = 2'(idx); alm_hh = 5'(h); alm_mm = 6'(m); alm_on = on;
        step();
        alm_we = 1'b0;
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        bit   ok;
        if (fin) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL scoreboard_drain: got %0d entries left, required 0", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (probe || sec_pulse || min_pulse || hour_pulse || day_pulse || set_err
                     || (alarm_hit != 4'b0000)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %0d:%0d:%0d pulses=%b err=%b hit=%b, required no event",
                         hh, mm, ss, {day_pulse, hour_pulse, min_pulse, sec_pulse}, set_err, alarm_hit);
            end else begin
                e  = q.pop_front();
                ok = (hh === e.hh) && (mm === e.mm) && (ss === e.ss) &&
                     ({day_pulse, hour_pulse, min_pulse, sec_pulse} === e.pulses) &&
                     (set_err === e.serr) && (alarm_hit === e.hit);
`ifdef TOD_BCD_OUT_EN
                if (e.use_bcd && ({bcd_hh, bcd_mm, bcd_ss} !== e.bcd))
                    ok = 1'b0;
`endif
                if (!ok) begin
                    bad++;
                    $display("FAIL %s: got %0d:%0d:%0d pulses=%b err=%b hit=%b, required %0d:%0d:%0d pulses=%b err=%b hit=%b",
                             e.tag, hh, mm, ss, {day_pulse, hour_pulse, min_pulse, sec_pulse}, set_err, alarm_hit,
                             e.hh, e.mm, e.ss, e.pulses, e.serr, e.hit);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary by time limit, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check_now("reset_state", 0, 0, 0, 4'b0000, 1'b0, 4'b0000);

        // Free run from reset: a tick every 4th edge, minute rollover on the 60th.
        reset = 1'b0;
        run   = 1'b1;
        for (int k = 1; k < 60; k++)
            expect_ev("sec_tick", 0, 0, k, 4'b0001, 1'b0, 4'b0000);
        repeat (240) step();
        check_now("min_rollover", 0, 1, 0, 4'b0011, 1'b0, 4'b0000);

        run = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check_now("paused", 0, 1, 0, 4'b0000, 1'b0, 4'b0000);
        end

        set_time(23, 59, 58);
        run = 1'b1;
        expect_ev("tick_235959", 23, 59, 59, 4'b0001, 1'b0, 4'b0000);
        repeat (8) step();
        check_now("day_rollover", 0, 0, 0, 4'b1111, 1'b0, 4'b0000);
        run = 1'b0;

        expect_ev("set_err_hh", 0, 0, 0, 4'b0000, 1'b1, 4'b0000);
        set_time(24, 10, 10);
        step();
        check_now("after_bad_hh", 0, 0, 0, 4'b0000, 1'b0, 4'b0000);
        expect_ev("set_err_mm", 0, 0, 0, 4'b0000, 1'b1, 4'b0000);
        set_time(5, 60, 10);
        step();
        check_now("after_bad_mm", 0, 0, 0, 4'b0000, 1'b0, 4'b0000);

        // Third edge leaves the prescaler at its wrap value; the set lands on the tick edge.
        run = 1'b1;
        repeat (3) step();
        set_time(10, 20, 30);
        check_now("set_beats_tick", 10, 20, 30, 4'b0000, 1'b0, 4'b0000);
        expect_ev("tick_after_set", 10, 20, 31, 4'b0001, 1'b0, 4'b0000);
        repeat (4) step();
        run = 1'b0;

        alm_write(2, 8, 0, 1'b1);
        alm_write(1, 8, 0, 1'b0);
        alm_write(3, 8, 0, 1'b1);
        alm_write(3, 8, 60, 1'b0);
        alm_write(0, 8, 1, 1'b1);
        alm_write(1, 24, 0, 1'b1);
        set_time(7, 59, 59);
        run = 1'b1;
        expect_ev("tick_0800", 8, 0, 0, 4'b0111, 1'b0, 4'b0000);
        repeat (5) step();
        check_now("alarm_hit_0800", 8, 0, 0, 4'b0000, 1'b0, 4'b1100);
        run = 1'b0;

        set_time(8, 0, 0);
        repeat (3) step();
        check_now("no_hit_on_set", 8, 0, 0, 4'b0000, 1'b0, 4'b0000);

        set_time(8, 0, 59);
        run = 1'b1;
        expect_ev("tick_0801", 8, 1, 0, 4'b0011, 1'b0, 4'b0000);
        repeat (5) step();
        check_now("alarm_hit_0801", 8, 1, 0, 4'b0000, 1'b0, 4'b0001);

        // Reset lands on the edge where a tick is due.
        repeat (2) step();
        reset = 1'b1;
        step();
        check_now("mid_reset", 0, 0, 0, 4'b0000, 1'b0, 4'b0000);
        reset = 1'b0;
        run   = 1'b0;
        step();
        set_time(7, 59, 59);
        run = 1'b1;
        expect_ev("tick_after_reset", 8, 0, 0, 4'b0111, 1'b0, 4'b0000);
        repeat (5) step();
        check_now("slots_cleared", 8, 0, 0, 4'b0000, 1'b0, 4'b0000);
        run = 1'b0;

`ifdef TOD_BCD_OUT_EN
        set_time(19, 45, 7);
        check_now("bcd_out", 19, 45, 7, 4'b0000, 1'b0, 4'b0000, {8'h19, 8'h45, 8'h07}, 1'b1);
`endif

        step();
        fin = 1'b1;
        repeat (5) step();
    end

endmodule

// File: doc/tod_alarm_clock.md
Name: tod_alarm_clock

Overview:
Parametrised time-of-day core for the dispenser: a prescaled seconds tick drives a cascaded ss/mm/hh counter.
- Adds over the fixed counter chain: software time-set, run/pause, single-cycle coincident rollover pulses, and NUM_ALARMS programmable hh:mm dose alarms.
- Sits between CLOCK_50 and the dispense controller and HEX display logic.

Parameters:
CLK_HZ, 50000000, CLOCK_50 cycles per second; prescaler wraps at CLK_HZ-1; bench uses small values, e.g. 4.
DAY_HOURS, 24, hours per day, legal 2..32; hh wraps at DAY_HOURS-1.
NUM_ALARMS, 4, number of alarm slots, 1..16; AW = max(1, clog2(NUM_ALARMS)).

Ports:
CLOCK_50  in  1  sole clock; all logic on posedge.
reset  in  1  synchronous, active-high.
run  in  1  1 = prescaler advances; 0 = time frozen, prescaler holds.
set_en  in  1  one-cycle strobe: load set_hh/set_mm/set_ss.
set_hh  in  5  hours to load.
set_mm  in  6  minutes to load.
set_ss  in  6  seconds to load.
set_err  out  1  one-cycle pulse: set_en had out-of-range values.
alm_we  in  1  alarm slot write strobe.
alm_idx  in  AW  slot index.
alm_hh  in  5  alarm hour.
alm_mm  in  6  alarm minute.
alm_on  in  1  slot enable.
hh  out  5  hours, binary.
mm  out  6  minutes, binary.
ss  out  6  seconds, binary.
sec_pulse  out  1  one cycle per second tick.
min_pulse  out  1  ss wrapped 59->0.
hour_pulse  out  1  mm wrapped 59->0.
day_pulse  out  1  hh wrapped DAY_HOURS-1->0.
alarm_hit  out  NUM_ALARMS  one-cycle per-slot match pulse.

Behaviour:
- Reset: hh=mm=ss=0, prescaler=0, all pulses=0, set_err=0, alarm_hit=0, every slot cleared to 00:00 and disabled. Reset mid-operation aborts any pending set or alarm write and drops any pulse in flight.
- Prescaler: counts only while run=1. At CLK_HZ-1 it wraps to 0 and the time advances by 1 s in that same edge.
- Pulse timing: sec_pulse is registered with the new ss, so it is high in the first cycle ss shows the new value. Over any CLK_HZ-cycle window with run=1 there is exactly one sec_pulse.
- Cascade: on a tick, ss==59 -> ss=0, mm+1, min_pulse. mm==59 also -> mm=0, hh+1, hour_pulse. hh==DAY_HOURS-1 also -> hh=0, day_pulse. All applicable pulses assert in the SAME cycle (no per-stage lag).
- Time-set: set_en with set_hh<DAY_HOURS, set_mm<60, set_ss<60 loads all three fields and clears the prescaler. No rollover pulses and no alarm evaluation result from a set.
- Invalid set: any field out of range -> time unchanged, set_err=1 for one cycle.
- Set vs tick: set_en has priority over a coincident tick; that tick is discarded.
- Alarm write: alm_we writes {alm_hh, alm_mm, alm_on} into slot alm_idx. If alm_idx>=NUM_ALARMS, or alm_hh>=DAY_HOURS, or alm_mm>=60, the write is ignored silently. The written slot is visible from the next cycle.
- Alarm match: when a tick (not a set) makes the time hh:mm:00 and slot i is enabled with matching hh/mm, alarm_hit[i]=1 for exactly one cycle. That is one cycle after the time outputs first show hh:mm:00. Multiple slots may hit together.
- Alarm edge cases: an alarm write in the same cycle as the matching tick compares against the old slot contents. Slots are never auto-disabled.
- run=0: no pulses; set and alarm writes still act.

Optional Feature:
Macro TOD_BCD_OUT_EN.
- Defined: adds outputs bcd_hh[7:0], bcd_mm[7:0], bcd_ss[7:0], tens nibble in [7:4] and units in [3:0]. Each is a combinational conversion of the registered binary field, so zero added latency.
- Undefined: those ports and their logic are absent; binary behaviour is identical in both builds.

Test Plan:
- CLK_HZ=4, run=1 from reset: sec_pulse every 4th cycle; after 240 cycles mm=1, ss=0, with min_pulse in the same cycle ss becomes 0.
- CLK_HZ=4, set 23:59:58, run=1: after 2 ticks hh=mm=ss=0, with min_pulse, hour_pulse and day_pulse all high in one cycle.
- set_en with set_hh=24 -> set_err one cycle, time unchanged. set_en coincident with a tick -> loaded value held and no sec_pulse that cycle.
- Slot 2 = 08:00 enabled, set 07:59:59, tick -> alarm_hit=4'b0100 one cycle after the display shows 08:00:00. Slot 1 with the same time but disabled -> no hit. Setting 08:00:00 directly -> no hit.
- run=0 for 100 cycles -> outputs constant, no pulses. Raise reset mid-count -> all outputs 0 next cycle and slots disabled.
- TOD_BCD_OUT_EN build: at 19:45:07, bcd_hh=8'h19, bcd_mm=8'h45, bcd_ss=8'h07.
